// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor for the 5-stage MIPS pipeline. Conditional
//   branches are predicted in D from a table of 2-bit saturating counters.
//   Each prediction is carried through E to M, where it is compared against
//   the resolved outcome to raise the redirect and to train the table.
//
// Parameters
//   INDEX_W       table index width; the table holds 2**INDEX_W counters
//
// Ports
//   clka          pipeline clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   pcD           PC of the instruction in D
//   branchD       instruction in D is a conditional branch
//   signimmD      sign-extended immediate of the instruction in D
//   actual_takeM  resolved outcome of the instruction in M (0 for non-branches)
//   pred_takeD    D-stage prediction (combinational)
//   pred_targetD  pcD + 4 + (signimmD << 2)
//   pred_takeM    prediction carried to M (0 for non-branches)
//   mispredictM   branch in M resolved against its prediction
//   pc_correctM   redirect PC: M target if taken, else M pc+4
//
// Configuration
//   BP_GSHARE_EN  when defined, the index is XORed with a global history
//                 register that is updated non-speculatively from M.

module branch_predictor #(
  parameter int unsigned INDEX_W = 6
) (
  input  logic        clka,
  input  logic        rst,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic [31:0] signimmD,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic [31:0] pred_targetD,
  output logic        pred_takeM,
  output logic        mispredictM,
  output logic [31:0] pc_correctM
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic               branch;
    logic               pred_take;
    logic [INDEX_W-1:0] idx;
    logic [31:0]        pc4;
    logic [31:0]        target;
  } stage_t;

  ctr_t               pht [ENTRIES];
  ctr_t               ctr_d;
  logic [INDEX_W-1:0] idx_d;
  logic [31:0]        pc4_d;
  stage_t             stage_d;
  stage_t             stage_e;
  stage_t             stage_m;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    case (c)
      STRONG_NT: r = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   r = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    r = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  r = taken ? STRONG_T : WEAK_T;
      default:   r = WEAK_NT;
    endcase
    return r;
  endfunction

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] ghr;

  // History only advances on resolved branches, so no repair is needed
  // after a flush.
  always_ff @(posedge clka) begin
    if (rst) begin
      ghr <= '0;
    end else if (stage_m.branch) begin
      ghr <= {ghr[INDEX_W-2:0], actual_takeM};
    end
  end

  assign idx_d = pcD[INDEX_W+1:2] ^ ghr;
`else
  assign idx_d = pcD[INDEX_W+1:2];
`endif

  // D-stage lookup. The table is read before this edge's training write,
  // so a same-index update in M is not visible until the next cycle.
  assign ctr_d        = pht[idx_d];
  assign pc4_d        = pcD + 32'd4;
  assign pred_targetD = pc4_d + (signimmD << 2);
  assign pred_takeD   = branchD & ctr_d[1];

  always_comb begin
    stage_d           = '0;
    stage_d.branch    = branchD;
    stage_d.pred_take = pred_takeD;
    stage_d.idx       = idx_d;
    stage_d.pc4       = pc4_d;
    stage_d.target    = pred_targetD;
  end

  // D->E and E->M registers; a mispredict squashes both wrong-path slots.
  always_ff @(posedge clka) begin
    if (rst) begin
      stage_e <= '0;
      stage_m <= '0;
    end else if (mispredictM) begin
      stage_e <= '0;
      stage_m <= '0;
    end else begin
      stage_e <= stage_d;
      stage_m <= stage_e;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht[i] <= WEAK_NT;
      end
    end else if (stage_m.branch) begin
      pht[stage_m.idx] <= sat_update(pht[stage_m.idx], actual_takeM);
    end
  end

  assign pred_takeM  = stage_m.pred_take;
  assign mispredictM = stage_m.branch & (actual_takeM != stage_m.pred_take);
  assign pc_correctM = actual_takeM ? stage_m.target : stage_m.pc4;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clka;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD;
  logic [31:0] signimmD;
  logic        actual_takeM;
  logic        pred_takeD;
  logic [31:0] pred_targetD;
  logic        pred_takeM;
  logic        mispredictM;
  logic [31:0] pc_correctM;

  branch_predictor #(.INDEX_W(6)) dut (
    .clka         (clka),
    .rst          (rst),
    .pcD          (pcD),
    .branchD      (branchD),
    .signimmD     (signimmD),
    .actual_takeM (actual_takeM),
    .pred_takeD   (pred_takeD),
    .pred_targetD (pred_targetD),
    .pred_takeM   (pred_takeM),
    .mispredictM  (mispredictM),
    .pc_correctM  (pc_correctM)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic [31:0] imm;
    logic        act;
    logic        exp_pd;
  } vec_t;

  typedef struct {
    logic        br;
    logic        act;
    logic        exp_pt;
    logic [31:0] exp_pcc;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic prefill();
    sb_t b;
    b.br = 1'b0; b.act = 1'b0; b.exp_pt = 1'b0; b.exp_pcc = 32'd0;
    sbq.delete();
    sbq.push_back(b);
    sbq.push_back(b);
  endtask

  // One pipeline cycle: present an instruction in D, drive the outcome of
  // whatever the scoreboard says sits in M, and check D and M outputs.
  task automatic cycle(input logic [31:0] pc, input logic br, input logic [31:0] imm,
                       input logic act, input logic exp_pd, input logic do_rst);
    sb_t         e;
    sb_t         m;
    logic [31:0] tgt;
    logic        mis;
    tgt          = pc + 32'd4 + (imm << 2);
    pcD          = pc;
    branchD      = br;
    signimmD     = imm;
    actual_takeM = sbq[0].act;
    e.br      = br;
    e.act     = act;
    e.exp_pt  = exp_pd;
    e.exp_pcc = act ? tgt : pc + 32'd4;
    sbq.push_back(e);
    @(negedge clka);
    check("pred_takeD", {31'd0, pred_takeD}, {31'd0, exp_pd});
    check("pred_targetD", pred_targetD, tgt);
    m   = sbq.pop_front();
    mis = m.br & (m.act != m.exp_pt);
    check("pred_takeM", {31'd0, pred_takeM}, {31'd0, m.exp_pt});
    check("mispredictM", {31'd0, mispredictM}, {31'd0, mis});
    if (mis) begin
      check("pc_correctM", pc_correctM, m.exp_pcc);
      // Wrong-path slots become bubbles; they carry outcome 1 so that any
      // leak through the flush would show as a mispredict or a training.
      foreach (sbq[i]) sbq[i] = '{br: 1'b0, act: 1'b1, exp_pt: 1'b0, exp_pcc: 32'd0};
    end
    if (do_rst) rst = 1'b1;
    @(posedge clka);
    #1;
    if (do_rst) begin
      rst = 1'b0;
      prefill();
    end
  endtask

  task automatic bubble();
    cycle(32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef BP_GSHARE_EN
    // Three taken branches whose PC index XOR history all land on 23,
    // then PC index 16 with GHR = 0b000111 must also read index 23.
    vecs.push_back('{32'h0000_005C, 1'b1, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_0058, 1'b1, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0050, 1'b1, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0040, 1'b1, 32'd0, 1'b0, 1'b1});
`else
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b1, 1'b0}); // 01->10, mispredict
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b1, 1'b1}); // 10->11
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b1, 1'b1}); // 5th taken, stays 11
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b0, 1'b1}); // 11->10
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b0, 1'b1}); // 10->01
    vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0003, 1'b0, 1'b0}); // 01->00
    vecs.push_back('{32'h0000_0080, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0}); // backward target
    vecs.push_back('{32'h0000_0080, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0}); // non-branch gated
    vecs.push_back('{32'h0000_0080, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1});
    vecs.push_back('{32'hFFFF_FFF0, 1'b1, 32'h0000_0010, 1'b0, 1'b0}); // target wraps
`endif

    rst          = 1'b1;
    pcD          = '0;
    branchD      = 1'b0;
    signimmD     = '0;
    actual_takeM = 1'b0;
    @(posedge clka);
    #1;
    rst = 1'b0;
    prefill();
    check("reset pred_takeM", {31'd0, pred_takeM}, 32'd0);
    check("reset mispredictM", {31'd0, mispredictM}, 32'd0);
    check("reset pc_correctM", pc_correctM, 32'd0);

    foreach (vecs[i]) begin
      cycle(vecs[i].pc, vecs[i].br, vecs[i].imm, vecs[i].act, vecs[i].exp_pd, 1'b0);
      bubble();
      bubble();
    end

`ifndef BP_GSHARE_EN
    // Flush: A (idx 0) mispredicts while B (idx 1) is in E and C (idx 2) in D.
    cycle(32'h0000_0200, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    cycle(32'h0000_0204, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    cycle(32'h0000_0208, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    bubble();
    bubble();
    // B's and C's counters must still be weak not-taken.
    cycle(32'h0000_0204, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    cycle(32'h0000_0208, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    bubble();
    bubble();

    // Collision: training of index 5 (01->10) while D reads index 5.
    cycle(32'h0000_0014, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
    bubble();
    cycle(32'h0000_0014, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0); // pre-update value
    cycle(32'h0000_0014, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0); // new value
    bubble();
    bubble();

    // Reset during a pending training write to index 3.
    cycle(32'h0000_000C, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);
    bubble();
    cycle(32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("midrst pred_takeM", {31'd0, pred_takeM}, 32'd0);
    check("midrst pc_correctM", pc_correctM, 32'd0);
    cycle(32'h0000_000C, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
    cycle(32'h0000_0040, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    bubble();
    bubble();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline. It predicts conditional branches in D and carries each prediction through E to M. In M it produces `pred_takeM` for the controller, which compares it against `actual_takeM` to clear its E/M control registers. It also raises the misprediction redirect (`mispredictM`, `pc_correctM`) to the PC mux and trains a table of 2-bit saturating counters.

## Interface
Parameters:
- `INDEX_W`, 6: table index width; the table holds 2^INDEX_W two-bit counters.

Ports:
- `clka`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pcD`  in  32  PC of the instruction in D.
- `branchD`  in  1  instruction in D is a conditional branch (controller `branch`).
- `signimmD`  in  32  sign-extended immediate of the instruction in D.
- `actual_takeM`  in  1  resolved outcome of the instruction in M; 0 for non-branches.
- `pred_takeD`  out  1  D-stage prediction; drives the early PC redirect.
- `pred_targetD`  out  32  `pcD + 4 + (signimmD << 2)`, mod 2^32.
- `pred_takeM`  out  1  prediction carried to M; 0 when the instruction in M is not a branch.
- `mispredictM`  out  1  `branchM & (actual_takeM != pred_takeM)`.
- `pc_correctM`  out  32  redirect PC: if `actual_takeM`, the M target; otherwise the M `pc+4`.

## Operation
- **Table:** 2^INDEX_W counters. 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- **Index:** `idxD = pcD[INDEX_W+1:2]`.
- **Prediction:** `pred_takeD = branchD & table[idxD][1]`, combinational. `pred_targetD` is combinational and valid regardless of `branchD`.
- **D→E and E→M pipeline registers** carry: `branch`, `pred_take`, `idx`, `pc+4`, `target`.
- **Pipeline flush:** when `mispredictM = 1`, both pipeline registers load zeros at the next edge. The wrong-path instructions then in D and E must not train the table or raise `mispredictM`.
- **Training:**
  - When `branchM = 1`, `table[idxM]` increments (saturating at 11) if `actual_takeM`, otherwise decrements (saturating at 00).
  - Non-branches in M do not train.
- **Read/write collision:** when D reads the index M is writing in the same cycle, D sees the pre-update value. There is no bypass.
- **Redirect:** `mispredictM` and `pc_correctM` are combinational from M-stage registers and `actual_takeM`. `pc_correctM` is don't-care when `mispredictM = 0`.

## Timing
- Prediction latency: 0 cycles, combinational in D.
- A prediction made in D at cycle t appears as `pred_takeM` at cycle t+2.
- A table update takes effect at the edge ending the M cycle. A lookup in the following cycle sees the new value.
- Reset values:
  - All counters = 01.
  - Pipeline registers = 0, so `pred_takeM = 0`, `mispredictM = 0`, `pc_correctM = 0`.
  - GHR = 0 (when the GHR is compiled in).
- Reset is asserted mid-operation: `rst` overrides everything, including a pending flush or training write.
- No stall input. The pipeline advances every cycle.

## Configuration
- Macro: `BP_GSHARE_EN`.
- **Defined:**
  - An INDEX_W-bit global history register (GHR) is added, reset to 0.
  - `idxD = pcD[INDEX_W+1:2] ^ GHR`.
  - On every edge with `branchM = 1` and no reset, `GHR <= {GHR[INDEX_W-2:0], actual_takeM}`. This update is non-speculative.
  - The index is piped to M, so training uses the index computed in D.
- **Undefined:** no GHR exists, and indexing is by PC only.

## Test plan
- **Reset:** assert `rst` 1 cycle, then present `branchD = 1`, `pcD = 0x0000_0040` → `pred_takeD = 0`. Two cycles later, `pred_takeM = 0`. With `actual_takeM = 0`, `mispredictM = 0`.
- **Training to taken:** branch at `pcD = 0x0000_0040`, `signimmD = 0x0000_0003`, resolves taken.
  - First pass: `pred_targetD = 0x0000_0050`, `mispredictM = 1`, `pc_correctM = 0x0000_0050`.
  - Second pass (counter now 10): `pred_takeD = 1` and no mispredict.
- **Saturation:** 5 consecutive taken resolutions at the same index leave the counter at 11. One not-taken resolution → 10, still predicts taken. A second not-taken → 01, predicts not-taken.
- **Flush:** branch A mispredicts in M while branch B sits in E → the next cycle has `branchM = 0` and `mispredictM = 0`, and B's index is untouched.
- **Collision:** training write to index 5 (01→10) coincides with a D lookup of index 5 → `pred_takeD = 0` this cycle, 1 the next.
- **Gshare (`BP_GSHARE_EN`):** after 3 taken branches, GHR = 0b000111 → lookup for `pcD = 0x0000_0040` (PC index 16) uses index 23.
